// File: rtl/tm1638_responder_pkg.sv
// Shared definitions for the TM1638 device-side responder: command classes,
// mode bit positions, memory sizes, FSM state encoding and key-stream packing.
package tm1638_responder_pkg;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam int READ_BIT    = 1;
    localparam int FIXED_BIT   = 2;
    localparam int DISP_ON_BIT = 3;

    localparam int RAM_WORDS = 16;
    localparam int KEY_BYTES = 4;
    localparam int KEY_BITS  = 8 * KEY_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WDATA  = 3'd2,
        ST_RDATA  = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    // Key byte i carries key 2i in bit 0 and key 2i+1 in bit 4; the rest are 0.
    function automatic logic [KEY_BITS-1:0] key_stream(input logic [7:0] keys);
        logic [KEY_BITS-1:0] s;
        s = {KEY_BITS{1'b0}};
        for (int i = 0; i < KEY_BYTES; i++) begin
            s[8*i]     = keys[2*i];
            s[8*i + 4] = keys[2*i + 1];
        end
        return s;
    endfunction

endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-stage synchronizer for one serial-link input with registered
// rise/fall pulses. The level output is delayed to line up with the pulses.
module tm1638_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              rise_r;
    logic              fall_r;

    // Synchronize the pad level (idle high) and register edge pulses.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            sync_r <= {STAGES{1'b1}};
            prev_r <= 1'b1;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
            rise_r <= sync_r[STAGES-1] & ~prev_r;
            fall_r <= ~sync_r[STAGES-1] & prev_r;
        end
    end

    assign level = prev_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes STB/CLK/DIO frames from the master,
// holds the 16-byte display RAM and display control, and serializes a key
// snapshot back on DIO during read frames.
module tm1638_responder
    import tm1638_responder_pkg::*;
#(
    parameter int C_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tm1638_strobe,
    input  logic       tm1638_clk,
    input  logic       tm1638_dio_in,
    output logic       tm1638_dio_out,
    output logic       tm1638_dio_oe,
    input  logic [7:0] key_state,
    input  logic [3:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       disp_on,
    output logic [2:0] brightness,
    output logic       cmd_err
);

    logic stb_lvl_s, stb_rise_s, stb_fall_s;
    logic clk_lvl_s, clk_rise_s, clk_fall_s;
    logic dio_lvl_s, dio_rise_s, dio_fall_s;
    logic unused_evt_s;

    tm1638_sync_edge #(.STAGES(C_SYNC_STAGES)) u_sync_stb (
        .clk(clk), .n_rst(n_rst), .din(tm1638_strobe),
        .level(stb_lvl_s), .rise(stb_rise_s), .fall(stb_fall_s)
    );

    tm1638_sync_edge #(.STAGES(C_SYNC_STAGES)) u_sync_clk (
        .clk(clk), .n_rst(n_rst), .din(tm1638_clk),
        .level(clk_lvl_s), .rise(clk_rise_s), .fall(clk_fall_s)
    );

    tm1638_sync_edge #(.STAGES(C_SYNC_STAGES)) u_sync_dio (
        .clk(clk), .n_rst(n_rst), .din(tm1638_dio_in),
        .level(dio_lvl_s), .rise(dio_rise_s), .fall(dio_fall_s)
    );

    // Only the DIO level and the STB/CLK edges drive the protocol.
    assign unused_evt_s = ^{stb_lvl_s, clk_lvl_s, dio_rise_s, dio_fall_s};

    state_t              state_r;
    logic [2:0]          bit_cnt_r;
    logic [7:0]          shift_r;
    logic                read_mode_r;
    logic                fixed_mode_r;
    logic [3:0]          addr_r;
    logic                disp_on_r;
    logic [2:0]          bright_r;
    logic [7:0]          key_snap_r;
    logic [5:0]          key_idx_r;
    logic                dio_oe_r;
    logic                dio_out_r;
    logic                wr_valid_r;
    logic [3:0]          wr_addr_r;
    logic [7:0]          wr_data_r;
    logic                cmd_err_r;
    logic [7:0]          ram_data_r;
    logic [7:0]          ram_r [RAM_WORDS];

    logic [7:0]          rx_byte_s;
    logic [KEY_BITS-1:0] key_stream_s;

    // Byte as it will look once the bit sampled on this CLK rise is shifted in.
    assign rx_byte_s    = {dio_lvl_s, shift_r[7:1]};
    assign key_stream_s = key_stream(key_snap_r);

    // Frame state machine: byte assembly, command decode, RAM writes, key serializer.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            read_mode_r  <= 1'b0;
            fixed_mode_r <= 1'b0;
            addr_r       <= 4'd0;
            disp_on_r    <= 1'b0;
            bright_r     <= 3'd0;
            key_snap_r   <= 8'h00;
            key_idx_r    <= 6'd0;
            dio_oe_r     <= 1'b0;
            dio_out_r    <= 1'b1;
            wr_valid_r   <= 1'b0;
            wr_addr_r    <= 4'd0;
            wr_data_r    <= 8'h00;
            cmd_err_r    <= 1'b0;
            for (int i = 0; i < RAM_WORDS; i++) begin
                ram_r[i] <= 8'h00;
            end
        end else begin
            wr_valid_r <= 1'b0;
            cmd_err_r  <= 1'b0;
            if (stb_rise_s) begin
                // End of frame wins over a coincident CLK edge; a partial byte is an error.
                if ((state_r != ST_IDLE) && (bit_cnt_r != 3'd0)) begin
                    cmd_err_r <= 1'b1;
                end
                state_r   <= ST_IDLE;
                dio_oe_r  <= 1'b0;
                bit_cnt_r <= 3'd0;
            end else if (stb_fall_s) begin
                state_r   <= ST_CMD;
                bit_cnt_r <= 3'd0;
            end else if (clk_rise_s && (state_r != ST_IDLE)) begin
                shift_r   <= rx_byte_s;
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    case (state_r)
                        ST_CMD: begin
                            case (rx_byte_s[7:6])
                                CMD_DATA: begin
                                    read_mode_r  <= rx_byte_s[READ_BIT];
                                    fixed_mode_r <= rx_byte_s[FIXED_BIT];
                                    if (rx_byte_s[READ_BIT]) begin
                                        key_snap_r <= key_state;
                                        key_idx_r  <= 6'd0;
                                        state_r    <= ST_RDATA;
                                    end else begin
                                        state_r    <= ST_IGNORE;
                                    end
                                end
                                CMD_DISP: begin
                                    disp_on_r <= rx_byte_s[DISP_ON_BIT];
                                    bright_r  <= rx_byte_s[2:0];
                                    state_r   <= ST_IGNORE;
                                end
                                CMD_ADDR: begin
                                    addr_r  <= rx_byte_s[3:0];
                                    state_r <= ST_WDATA;
                                end
                                default: begin
                                    cmd_err_r <= 1'b1;
                                    state_r   <= ST_IGNORE;
                                end
                            endcase
                        end
                        ST_WDATA: begin
                            ram_r[addr_r] <= rx_byte_s;
                            wr_valid_r    <= 1'b1;
                            wr_addr_r     <= addr_r;
                            wr_data_r     <= rx_byte_s;
                            if (!fixed_mode_r) begin
                                addr_r <= addr_r + 4'd1;
                            end
                        end
                        default: begin
                            state_r <= state_r;
                        end
                    endcase
                end
            end else if (clk_fall_s && (state_r == ST_RDATA)) begin
                dio_oe_r <= 1'b1;
                if (key_idx_r < 6'd32) begin
                    dio_out_r <= key_stream_s[key_idx_r[4:0]];
                    key_idx_r <= key_idx_r + 6'd1;
                end else begin
                    dio_out_r <= 1'b0;
                end
            end
        end
    end

    // Registered display-RAM read port; a same-cycle write returns old data.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            ram_data_r <= 8'h00;
        end else begin
            ram_data_r <= ram_r[ram_addr];
        end
    end

    assign tm1638_dio_out = dio_out_r;
    assign tm1638_dio_oe  = dio_oe_r;
    assign ram_data       = ram_data_r;
    assign wr_valid       = wr_valid_r;
    assign wr_addr        = wr_addr_r;
    assign wr_data        = wr_data_r;
    assign disp_on        = disp_on_r;
    assign brightness     = bright_r;
    assign cmd_err        = cmd_err_r;

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: bit-banged master frames, a write
// scoreboard fed at stimulus time and drained from wr_valid, and key-read checks.
module tb_tm1638_responder;

    localparam int S = 2;
    localparam int H = 8;  // system cycles per serial half period

    logic       sys_clk = 1'b0;
    logic       n_rst;
    logic       stb, sclk, dio_in;
    logic       dio_out, dio_oe;
    logic [7:0] key_state;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       disp_on;
    logic [2:0] brightness;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    logic [11:0] wr_q[$];
    logic [7:0]  rd_q[$];

    tm1638_responder #(.C_SYNC_STAGES(S)) dut (
        .clk(sys_clk), .n_rst(n_rst),
        .tm1638_strobe(stb), .tm1638_clk(sclk), .tm1638_dio_in(dio_in),
        .tm1638_dio_out(dio_out), .tm1638_dio_oe(dio_oe),
        .key_state(key_state), .ram_addr(ram_addr), .ram_data(ram_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .disp_on(disp_on), .brightness(brightness), .cmd_err(cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic start_frame();
        stb = 1'b0;
        cyc(H);
    endtask

    task automatic stop_frame();
        stb = 1'b1;
        cyc(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            dio_in = b[i];
            cyc(H);
            sclk = 1'b1;
            cyc(H);
        end
        dio_in = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic frame1(input logic [7:0] b);
        start_frame();
        send_byte(b);
        stop_frame();
    endtask

    // Write a data byte and record the expected wr_valid beat.
    task automatic send_wr(input logic [3:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        send_byte(d);
    endtask

    // Master read of one byte: sample DIO just before each CLK rise.
    task automatic read_byte(output logic [7:0] b, output logic oe_all);
        oe_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b0;
            cyc(H);
            b[i] = dio_out;
            oe_all = oe_all & dio_oe;
            sclk = 1'b1;
            cyc(H);
        end
    endtask

    task automatic check_ram(input logic [3:0] a, input logic [7:0] exp, input string tag);
        ram_addr = a;
        cyc(2);
        chk(tag, ram_data, exp);
    endtask

    // Scoreboard drain and cmd_err pulse counter, sampled on the inactive edge.
    always @(negedge sys_clk) begin
        if (n_rst === 1'b0) begin
            if (wr_valid === 1'b1) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", {20'h0, wr_addr, wr_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("wr_beat", {20'h0, wr_addr, wr_data}, {20'h0, wr_q.pop_front()});
                end
            end
            if (cmd_err === 1'b1) begin
                err_cnt++;
            end
        end
    end

    initial begin
        logic [7:0] rb;
        logic       oe_ok;
        int         e0;

        n_rst = 1'b1; stb = 1'b1; sclk = 1'b1; dio_in = 1'b1;
        key_state = 8'h00; ram_addr = 4'd0;
        cyc(5);
        n_rst = 1'b0;
        cyc(5);

        // Reset state
        chk("rst_dio_oe", dio_oe, 1'b0);
        chk("rst_dio_out", dio_out, 1'b1);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        chk("rst_disp", {disp_on, brightness}, 4'h0);
        chk("rst_ram_data", ram_data, 8'h00);

        // Auto-increment write across the whole RAM
        frame1(8'h40);
        start_frame();
        send_byte(8'hC0);
        for (int i = 0; i < 16; i++) send_wr(i[3:0], 8'(i + 1));
        stop_frame();
        check_ram(4'd15, 8'h10, "auto_ram15");
        check_ram(4'd0, 8'h01, "auto_ram0");

        // Fixed-address writes
        frame1(8'h44);
        start_frame();
        send_byte(8'hC5);
        send_wr(4'd5, 8'hAA);
        send_wr(4'd5, 8'hBB);
        stop_frame();
        check_ram(4'd5, 8'hBB, "fixed_ram5");
        check_ram(4'd6, 8'h07, "fixed_ram6");

        // Address wrap 15 -> 0 in auto mode
        frame1(8'h40);
        start_frame();
        send_byte(8'hC0);
        send_wr(4'd0, 8'hEE);
        stop_frame();
        start_frame();
        send_byte(8'hCF);
        send_wr(4'd15, 8'h11);
        send_wr(4'd0, 8'h22);
        stop_frame();
        check_ram(4'd15, 8'h11, "wrap_ram15");
        check_ram(4'd0, 8'h22, "wrap_ram0");

        // Key read; keys change after the command to show the snapshot holds
        key_state = 8'b1000_0001;
        rd_q.push_back(8'h01); rd_q.push_back(8'h00);
        rd_q.push_back(8'h00); rd_q.push_back(8'h10);
        start_frame();
        send_byte(8'h42);
        key_state = 8'hFF;
        chk("rd_oe_before", dio_oe, 1'b0);
        for (int k = 0; k < 4; k++) begin
            read_byte(rb, oe_ok);
            chk("rd_byte", rb, rd_q.pop_front());
            chk("rd_oe_during", oe_ok, 1'b1);
        end
        stb = 1'b1;
        cyc(S + 1);
        chk("rd_oe_hold", dio_oe, 1'b1);
        cyc(1);
        chk("rd_oe_clear", dio_oe, 1'b0);
        cyc(H);
        key_state = 8'h00;

        // Display control, then an invalid command class
        frame1(8'h8F);
        chk("disp_set", {disp_on, brightness}, 4'hF);
        e0 = err_cnt;
        frame1(8'h20);
        chk("bad_cmd_err", err_cnt - e0, 1);
        chk("bad_cmd_disp", {disp_on, brightness}, 4'hF);

        // Partial data byte is discarded with an error
        frame1(8'h40);
        e0 = err_cnt;
        start_frame();
        send_byte(8'hC3);
        send_bits(8'h05, 4);
        stop_frame();
        chk("partial_err", err_cnt - e0, 1);
        check_ram(4'd3, 8'h04, "partial_ram3");

        // Reset mid-frame
        start_frame();
        send_byte(8'hC7);
        send_bits(8'h0F, 3);
        n_rst = 1'b1;
        stb = 1'b1;
        sclk = 1'b1;
        cyc(3);
        chk("mid_rst_disp", {disp_on, brightness}, 4'h0);
        chk("mid_rst_dio", {dio_oe, dio_out}, 2'b01);
        chk("mid_rst_pulses", {wr_valid, cmd_err}, 2'b00);
        chk("mid_rst_ram_data", ram_data, 8'h00);
        n_rst = 1'b0;
        cyc(H);
        check_ram(4'd5, 8'h00, "mid_rst_ram5");

        chk("wr_q_drained", wr_q.size(), 0);
        chk("cmd_err_total", err_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
